// File: rtl/adder_pkg.sv
// Shared definitions for the adder study: FSM encoding, default width and
// the one-bit carry function reused by the parallel and serial adders.
package adder_pkg;

  localparam int ADDER_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic logic majority(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/serial_bit_cell.sv
// Single-bit full-add slice: the only arithmetic in the serial adder.
module serial_bit_cell
  import adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  assign s     = a ^ b ^ c_in;
  assign c_out = majority(a, b, c_in);

endmodule

// File: rtl/bit_serial_adder_ctrl.sv
// Bit-serial adder: latches operands, resolves one bit per clock LSB first,
// and presents {cout,sum} with a one-cycle done pulse.
module bit_serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter  int WIDTH = ADDER_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_sh, b_sh;
  logic               carry;
  logic [CNT_W-1:0]   cnt;
  logic               bit_s, bit_c;
  logic               last;

  assign last = (cnt == CNT_W'(WIDTH - 1));

  serial_bit_cell u_cell (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .c_in  (carry),
    .s     (bit_s),
    .c_out (bit_c)
  );

  // NOTE: clocked blocks use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: state_nxt gets a default first so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:  busy = 1'b1;
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // NOTE: datapath flops are reset along with control so an aborted add leaves nothing behind on sum/cout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sh  <= a;
          b_sh  <= b;
          carry <= cin;
          cnt   <= '0;
          sum   <= '0;
        end
        RUN: begin
          sum   <= {bit_s, sum[WIDTH-1:1]};
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= bit_c;
          // Counter parks at WIDTH-1 so it never wraps into a stray shift.
          if (last) cout <= bit_c;
          else      cnt  <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// Scoreboard bench for bit_serial_adder_ctrl at WIDTH=16: directed corner
// cases, start-held, mid-run reset and a back-to-back random run.
module tb_bit_serial_adder_ctrl;

  localparam int W = 16;

  typedef struct packed {
    logic         cout;
    logic [W-1:0] sum;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  int     n_checks = 0;
  int     n_fail   = 0;
  int     done_cnt = 0;
  longint cyc      = 0;
  res_t   exp_q[$];

  bit_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: every done pulse pops one expected result.
  always @(negedge clk) begin
    res_t e;
    if (rst_n === 1'b1 && done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("sum", 64'(sum), 64'(e.sum));
        check("cout", 64'(cout), 64'(e.cout));
      end
    end
  end

  function automatic res_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci);
    logic [W:0] t;
    t = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, ci};
    return res_t'(t);
  endfunction

  // Called at a negedge with the DUT idle. Returns at the idle negedge after
  // done, so a following call starts back-to-back.
  task automatic run_add(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                         input bit hold, output int edges, output int busy_cycles,
                         output longint done_at);
    bit found;
    a = av; b = bv; cin = ci; start = 1'b1;
    exp_q.push_back(model(av, bv, ci));
    @(posedge clk);
    found = 0; edges = -1; busy_cycles = 0; done_at = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      if (busy === 1'b1) busy_cycles++;
      if (done === 1'b1) begin
        found = 1; edges = k; done_at = cyc; start = 1'b0;
      end
    end
    if (!found) check("done_timeout", 64'd0, 64'd1);
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);
    check("done_width", 64'(done), 64'd0);
  endtask

  initial begin
    int     edges, bcyc, d0;
    longint t_done, t_prev;
    logic [W-1:0] ra, rb;
    logic         rc;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Done is seen in the cycle after edge E16 (negedge index 16); busy covers 17 cycles.
    run_add(16'h1234, 16'h4321, 1'b0, 0, edges, bcyc, t_done);
    check("latency_edges", 64'(edges), 64'(W));
    check("busy_cycles", 64'(bcyc), 64'(W + 1));

    run_add(16'hFFFF, 16'h0001, 1'b0, 0, edges, bcyc, t_done);
    run_add(16'hFFFF, 16'hFFFF, 1'b1, 0, edges, bcyc, t_done);
    run_add(16'h0000, 16'h0000, 1'b1, 0, edges, bcyc, t_done);

    // start held high through RUN with changing operands: one result, one pulse.
    d0 = done_cnt;
    run_add(16'hA5A5, 16'h0F0F, 1'b1, 1, edges, bcyc, t_done);
    repeat (4) @(negedge clk);
    check("held_start_dones", 64'(done_cnt - d0), 64'd1);
    check("held_start_idle", 64'(busy), 64'd0);

    // Reset one cycle at cnt=7 (negedge after E7) aborts without a done.
    d0 = done_cnt;
    a = 16'hBEEF; b = 16'h1357; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_sum", 64'(sum), 64'd0);
    check("abort_cout", 64'(cout), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    check("abort_idle", 64'(busy), 64'd0);
    run_add(16'h00FF, 16'h0F0F, 1'b0, 0, edges, bcyc, t_done);

    // Back-to-back random adds; consecutive done pulses are WIDTH+2 cycles apart.
    t_prev = 0;
    for (int i = 0; i < 200; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      run_add(ra, rb, rc, 0, edges, bcyc, t_done);
      if (i > 0) check("done_spacing", 64'(t_done - t_prev), 64'(W + 2));
      t_prev = t_done;
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
